// File: rtl/usb2_crc_pkg.sv
// rtl/usb2_crc_pkg.sv - CRC5 helpers, PID codes and framer state type for USB 2.0 token packets
// Purpose: shared constants and bit-serial CRC5 functions for token/SOF framing.
// Contents: CRC5_POLY, CRC5_SEED_DEFAULT, PID_* codes, tf_state_e,
//           crc5_update_bit (one input bit), crc5_field11 (11-bit token field).
package usb2_crc_pkg;

  localparam logic [4:0] CRC5_POLY         = 5'h05;  // x^5 + x^2 + 1
  localparam logic [4:0] CRC5_SEED_DEFAULT = 5'h1F;

  localparam logic [3:0] PID_OUT   = 4'h1;
  localparam logic [3:0] PID_IN    = 4'h9;
  localparam logic [3:0] PID_SOF   = 4'h5;
  localparam logic [3:0] PID_SETUP = 4'hD;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tf_state_e;

  // Shift one wire bit into the CRC register (MSB-out Galois form).
  function automatic logic [4:0] crc5_update_bit(input logic [4:0] crc, input logic din);
    logic fb;
    fb = crc[4] ^ din;
    return {crc[3:0], 1'b0} ^ (fb ? CRC5_POLY : 5'h00);
  endfunction

  // Field bits enter in wire order: field[0] first. The loop unrolls to pure logic.
  function automatic logic [4:0] crc5_field11(input logic [4:0] seed, input logic [10:0] field);
    logic [4:0] crc;
    crc = seed;
    for (int i = 0; i < 11; i++) begin
      crc = crc5_update_bit(crc, field[i]);
    end
    return crc;
  endfunction

endpackage

// File: rtl/usb2_token_crc5_calc.sv
// rtl/usb2_token_crc5_calc.sv - combinational CRC5 for an 11-bit token field, in transmit bit order
// Purpose: field -> crc_tx, ready to be placed above the field in the 16-bit token word.
// Ports: field_i  [10:0] token field {endp, addr} or SOF frame number
//        crc_tx_o [4:0]  remainder (optionally inverted), bit-reversed so bit 0 goes out first
module usb2_token_crc5_calc
  import usb2_crc_pkg::*;
#(
  parameter logic [4:0] RESET_SEED = CRC5_SEED_DEFAULT,
  parameter bit         INVERT_CRC = 1'b1
) (
  input  logic [10:0] field_i,
  output logic [4:0]  crc_tx_o
);

  logic [4:0] rem;

  always_comb begin
    crc_tx_o = '0;
    rem      = crc5_field11(RESET_SEED, field_i);
    if (INVERT_CRC) begin
      rem = ~rem;
    end
    // The remainder MSB is the first CRC bit on the wire, i.e. the lowest crc_tx bit.
    for (int i = 0; i < 5; i++) begin
      crc_tx_o[i] = rem[4 - i];
    end
  end

endmodule

// File: rtl/usb2_token_framer.sv
// rtl/usb2_token_framer.sv - USB 2.0 token/SOF packet framer emitting 4-bit nibbles, LSB first
// Purpose: accept {pid, field}, attach ~pid and CRC5, stream six nibbles to the NRZI/stuff path.
// Ports: CLK, RST (sync, active-high)
//        in_valid/in_ready/in_pid[3:0]/in_field[10:0]   request handshake
//        out_valid/out_ready/out_data[3:0]/out_last     nibble stream, out_last on 6th nibble
//        busy                                           a packet is held or being sent
module usb2_token_framer
  import usb2_crc_pkg::*;
#(
  parameter logic [4:0] RESET_SEED = CRC5_SEED_DEFAULT,
  parameter bit         INVERT_CRC = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_pid,
  input  logic [10:0] in_field,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_data,
  output logic        out_last,
  output logic        busy
);

  tf_state_e   state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [3:0]  pid_q, pid_d;
  logic [10:0] field_q, field_d;
  logic [4:0]  crc_q, crc_d;
  logic [4:0]  crc_new;
  logic [3:0]  out_data_q, out_data_d;
  logic        out_last_q, out_last_d;
  logic [23:0] pkt_d;
  logic        last_fire;
  logic        accept;

  usb2_token_crc5_calc #(
    .RESET_SEED (RESET_SEED),
    .INVERT_CRC (INVERT_CRC)
  ) u_crc (
    .field_i  (in_field),
    .crc_tx_o (crc_new)
  );

  // The final nibble leaving this cycle frees the packet buffer, so a new request
  // can load in the same cycle and the stream has no bubble between packets.
  assign last_fire = (state_q == ST_SEND) && (idx_q == 3'd5) && out_ready;
  assign in_ready  = !RST && ((state_q == ST_IDLE) || last_fire);
  assign accept    = in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    pid_d      = pid_q;
    field_d    = field_q;
    crc_d      = crc_q;
    pkt_d      = '0;
    out_data_d = '0;
    out_last_d = 1'b0;

    if (accept) begin
      pid_d   = in_pid;
      field_d = in_field;
      crc_d   = crc_new;
      idx_d   = 3'd0;
      state_d = ST_SEND;
    end else if ((state_q == ST_SEND) && out_ready) begin
      if (idx_q == 3'd5) begin
        idx_d   = 3'd0;
        state_d = ST_IDLE;
      end else begin
        idx_d = idx_q + 3'd1;
      end
    end

    // Output nibble is selected from next-state values so out_data/out_last are
    // registers that already show the nibble idx_q points at.
    pkt_d = {crc_d, field_d, ~pid_d, pid_d};
    if (state_d == ST_SEND) begin
      out_data_d = pkt_d[{idx_d, 2'b00} +: 4];
      out_last_d = (idx_d == 3'd5);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      idx_q      <= 3'd0;
      pid_q      <= 4'd0;
      field_q    <= 11'd0;
      crc_q      <= 5'd0;
      out_data_q <= 4'd0;
      out_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      pid_q      <= pid_d;
      field_q    <= field_d;
      crc_q      <= crc_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
    end
  end

  assign out_valid = (state_q == ST_SEND);
  assign busy      = (state_q == ST_SEND);
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_usb2_token_framer.sv
// tb/tb_usb2_token_framer.sv - self-checking bench for usb2_token_framer
module tb_usb2_token_framer;
  import usb2_crc_pkg::*;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RST = 1'b1;
  // DUT a: default (inverted CRC) build
  logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_last, busy;
  logic [3:0]  in_pid = '0, out_data;
  logic [10:0] in_field = '0;
  // DUT b: raw-remainder build
  logic        in_valid_b = 1'b0, in_ready_b, out_valid_b, out_ready_b = 1'b1, out_last_b, busy_b;
  logic [3:0]  in_pid_b = '0, out_data_b;
  logic [10:0] in_field_b = '0;

  usb2_token_framer u_dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready), .in_pid(in_pid),
    .in_field(in_field), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  usb2_token_framer #(.RESET_SEED(5'h1F), .INVERT_CRC(1'b0)) u_dut_raw (
    .CLK(CLK), .RST(RST), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_pid(in_pid_b),
    .in_field(in_field_b), .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .out_last(out_last_b), .busy(busy_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference packet: CRC by long division of the field (LSB first) from seed 1F.
  function automatic logic [23:0] m_pkt(input logic [3:0] pid, input logic [10:0] f, input bit inv);
    int r;
    int top;
    logic [4:0] rem, tx;
    r = 31;
    for (int i = 0; i < 11; i++) begin
      top = (r >> 4) & 1;
      r = (r << 1) & 31;
      if (top != int'(f[i])) r = r ^ 5;
    end
    rem = r[4:0];
    if (inv) rem = ~rem;
    for (int i = 0; i < 5; i++) tx[i] = rem[4 - i];
    return {tx, f, ~pid, pid};
  endfunction

  // Scoreboard queues hold {last, nibble}; obs queues record transferred nibbles.
  logic [4:0] qa[$], qb[$];
  logic [3:0] obsa[$], obsb[$];
  logic [23:0] pa, pb;
  logic exp_rdy_a, exp_rdy_b;
  int vrun = 0, vmax = 0;

  always @(negedge CLK) begin
    if (RST) begin
      qa.delete();
      vrun = 0;
      chk("a_in_ready_rst", in_ready, 1'b0);
    end else begin
      exp_rdy_a = (qa.size() == 0) || (qa.size() == 1 && out_ready);
      chk("a_in_ready", in_ready, exp_rdy_a);
      chk("a_out_valid", out_valid, qa.size() != 0);
      chk("a_busy", busy, qa.size() != 0);
      if (out_valid && qa.size() != 0) begin
        chk("a_out_data", out_data, qa[0][3:0]);
        chk("a_out_last", out_last, qa[0][4]);
        if (out_ready) begin
          obsa.push_back(out_data);
          void'(qa.pop_front());
        end
      end
      if (in_valid && exp_rdy_a) begin
        pa = m_pkt(in_pid, in_field, 1'b1);
        for (int k = 0; k < 6; k++) qa.push_back({k == 5, pa[4*k +: 4]});
      end
      vrun = out_valid ? vrun + 1 : 0;
      if (vrun > vmax) vmax = vrun;
    end
  end

  always @(negedge CLK) begin
    if (RST) begin
      qb.delete();
    end else begin
      exp_rdy_b = (qb.size() == 0) || (qb.size() == 1 && out_ready_b);
      chk("b_in_ready", in_ready_b, exp_rdy_b);
      chk("b_out_valid", out_valid_b, qb.size() != 0);
      if (out_valid_b && qb.size() != 0) begin
        chk("b_out_data", out_data_b, qb[0][3:0]);
        chk("b_out_last", out_last_b, qb[0][4]);
        if (out_ready_b) begin
          obsb.push_back(out_data_b);
          void'(qb.pop_front());
        end
      end
      if (in_valid_b && exp_rdy_b) begin
        pb = m_pkt(in_pid_b, in_field_b, 1'b0);
        for (int k = 0; k < 6; k++) qb.push_back({k == 5, pb[4*k +: 4]});
      end
    end
  end

  // out_ready pattern: mode 0 always ready, mode 1 repeats 1,0,0.
  int rdy_mode = 0;
  int cyc = 0;
  initial forever begin
    @(posedge CLK);
    #1;
    cyc++;
    out_ready = (rdy_mode == 0) ? 1'b1 : (cyc % 3 == 0);
  end

  task automatic send_a(input logic [3:0] p, input logic [10:0] f);
    int n;
    in_valid = 1'b1; in_pid = p; in_field = f;
    n = 0;
    do begin @(negedge CLK); n++; end while (!in_ready && n < 200);
    if (!in_ready) chk("a_accept_timeout", 0, 1);
    @(posedge CLK); #1;
    in_valid = 1'b0; in_pid = 4'($urandom); in_field = 11'($urandom);
  endtask

  task automatic send_b(input logic [3:0] p, input logic [10:0] f);
    int n;
    in_valid_b = 1'b1; in_pid_b = p; in_field_b = f;
    n = 0;
    do begin @(negedge CLK); n++; end while (!in_ready_b && n < 200);
    if (!in_ready_b) chk("b_accept_timeout", 0, 1);
    @(posedge CLK); #1;
  endtask

  task automatic wait_idle_a();
    int n;
    n = 0;
    do begin @(posedge CLK); #2; n++; end while ((qa.size() != 0 || out_valid) && n < 500);
    if (qa.size() != 0 || out_valid) chk("a_idle_timeout", 0, 1);
  endtask

  function automatic logic [23:0] pack_a();
    logic [23:0] v;
    v = '0;
    for (int k = 0; k < 6; k++) if (k < obsa.size()) v[4*k +: 4] = obsa[k];
    return v;
  endfunction

  logic [23:0] got;
  int n;

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 4'h0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_in_ready_high", in_ready, 1'b0);
    RST = 1'b0;
    @(negedge CLK);
    chk("in_ready_after_release", in_ready, 1'b1);
    @(posedge CLK); #1;

    // SETUP addr 15 endp E: nibbles D,2,5,1,F,E; CRC wire order 10111
    obsa.delete();
    send_a(PID_SETUP, {4'hE, 7'h15});
    wait_idle_a();
    got = pack_a();
    chk("setup_nibbles", got, 24'hEF152D);
    chk("setup_crc_wire", {got[19], got[20], got[21], got[22], got[23]}, 5'b10111);
    chk("setup_count", obsa.size(), 6);

    // Same request with out_ready stalling
    rdy_mode = 1;
    obsa.delete();
    send_a(PID_SETUP, {4'hE, 7'h15});
    wait_idle_a();
    chk("stall_nibbles", pack_a(), 24'hEF152D);
    chk("stall_count", obsa.size(), 6);
    rdy_mode = 0;
    @(posedge CLK); #1;

    // Back-to-back OUT / IN with no bubble
    obsa.delete();
    vmax = 0;
    send_a(PID_OUT, 11'h000);
    send_a(PID_IN, 11'h7FF);
    wait_idle_a();
    chk("b2b_valid_run", vmax, 12);
    chk("b2b_count", obsa.size(), 12);

    // Reset while idx == 3
    obsa.delete();
    send_a(PID_OUT, 11'h123);
    n = 0;
    while (obsa.size() < 3 && n < 100) begin @(posedge CLK); #2; n++; end
    chk("pre_reset_progress", obsa.size(), 3);
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_out_data", out_data, 4'h0);
    chk("midrst_out_last", out_last, 1'b0);
    RST = 1'b0;
    @(posedge CLK); #1;
    obsa.delete();
    send_a(PID_SETUP, {4'hE, 7'h15});
    wait_idle_a();
    chk("post_rst_nibbles", pack_a(), 24'hEF152D);

    // Raw-remainder build: every SOF frame number, streamed back to back
    obsb.delete();
    for (int f = 0; f < 2048; f++) send_b(PID_SOF, 11'(f));
    in_valid_b = 1'b0;
    n = 0;
    while ((qb.size() != 0 || out_valid_b) && n < 100) begin @(posedge CLK); #2; n++; end
    chk("raw_count", obsb.size(), 2048 * 6);
    got = '0;
    for (int k = 0; k < 6; k++) if (k < obsb.size()) got[4*k +: 4] = obsb[k];
    chk("raw_sof0_nibbles", got, 24'hE800A5);

    repeat (2) @(posedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
